// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher encode/decode paths: alphabet constants,
// decoder FSM encoding, FIFO entry layout and mod-26 arithmetic helpers.
package cipher_pkg;

  localparam int unsigned ALPHA_LEN = 26;
  localparam int unsigned CHAR_W    = 5;
  localparam int unsigned SUM_W     = CHAR_W + 1;
  localparam int unsigned ENTRY_W   = CHAR_W + 1;

  localparam logic [CHAR_W-1:0] CHAR_INVALID = 5'd31;

  typedef enum logic {
    ST_NOKEY = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // One queued output symbol: error flag on top, letter below.
  typedef struct packed {
    logic              err;
    logic [CHAR_W-1:0] data;
  } fifo_entry_t;

  // Fold a raw 5-bit value (0..31) into the alphabet range (0..25).
  function automatic logic [CHAR_W-1:0] mod26_reduce(input logic [CHAR_W-1:0] x);
    return (x >= CHAR_W'(ALPHA_LEN)) ? x - CHAR_W'(ALPHA_LEN) : x;
  endfunction

  // (a + b) mod 26 for a, b in 0..25; 6-bit sum with one conditional subtract.
  function automatic logic [CHAR_W-1:0] mod26_add(input logic [CHAR_W-1:0] a,
                                                  input logic [CHAR_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SUM_W'(ALPHA_LEN)) s = s - SUM_W'(ALPHA_LEN);
    return s[CHAR_W-1:0];
  endfunction

  // (a - b) mod 26 for a, b in 0..25; borrows by adding 26 when a < b.
  function automatic logic [CHAR_W-1:0] mod26_sub(input logic [CHAR_W-1:0] a,
                                                  input logic [CHAR_W-1:0] b);
    logic [SUM_W-1:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + SUM_W'(ALPHA_LEN) - {1'b0, b};
    return s[CHAR_W-1:0];
  endfunction

endpackage

// File: rtl/cipher_fifo.sv
// Synchronous FIFO with registered storage and occupancy counter.
// Ports: clk, resetn (async, active-low); i_push/i_wdata write side;
// i_pop read side; o_rdata always shows the head entry; o_full/o_empty flags.
// Pushes while full and pops while empty are ignored.
module cipher_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr];

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/caesar_stream_decoder.sv
// Streaming Caesar / rolling-key decoder.
// Ports: clk, resetn (async, active-low);
//   key_load/key_in/step_in/roll_en   key setup (values 26..31 folded at load)
//   in_valid/in_data/in_ready          ciphertext input handshake
//   out_valid/out_data/out_err/out_ready  plaintext output from the FIFO head
//   key_cur    key applied to the next accepted symbol
//   sym_count  symbols accepted since last key_load/reset (wraps)
module caesar_stream_decoder
  import cipher_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              key_load,
  input  logic [4:0]        key_in,
  input  logic [4:0]        step_in,
  input  logic              roll_en,
  input  logic              in_valid,
  input  logic [4:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [4:0]        out_data,
  output logic              out_err,
  input  logic              out_ready,
  output logic [4:0]        key_cur,
  output logic [CNT_W-1:0]  sym_count
);

  state_t             r_state;
  logic [CHAR_W-1:0]  r_key;
  logic [CHAR_W-1:0]  r_step;
  logic               r_roll;
  logic [CNT_W-1:0]   r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_pop;
  logic               w_in_err;
  fifo_entry_t        w_push_entry;
  fifo_entry_t        w_head;
  logic [ENTRY_W-1:0] w_push_bits;
  logic [ENTRY_W-1:0] w_head_bits;

  // key_load takes priority over an incoming symbol; no pass-through when full.
  assign in_ready  = (r_state == ST_RUN) && !w_full && !key_load;
  assign w_accept  = in_valid && in_ready;
  assign w_in_err  = (in_data > CHAR_W'(ALPHA_LEN - 1));
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  // Decoded entry for the current input symbol.
  always_comb begin
    w_push_entry = '0;
    if (w_in_err) begin
      w_push_entry.err  = 1'b1;
      w_push_entry.data = CHAR_INVALID;
    end else begin
      w_push_entry.data = mod26_sub(in_data, r_key);
    end
  end

  assign w_push_bits = w_push_entry;
  assign w_head      = fifo_entry_t'(w_head_bits);
  assign out_data    = w_head.data;
  assign out_err     = w_head.err;
  assign key_cur     = r_key;
  assign sym_count   = r_count;

  cipher_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_accept),
    .i_wdata (w_push_bits),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Control FSM with key, step, roll flag and symbol counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_NOKEY;
      r_key   <= '0;
      r_step  <= '0;
      r_roll  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_NOKEY: begin
          if (key_load) begin
            r_state <= ST_RUN;
            r_key   <= mod26_reduce(key_in);
            r_step  <= mod26_reduce(step_in);
            r_roll  <= roll_en;
            r_count <= '0;
          end
        end
        ST_RUN: begin
          if (key_load) begin
            r_key   <= mod26_reduce(key_in);
            r_step  <= mod26_reduce(step_in);
            r_roll  <= roll_en;
            r_count <= '0;
          end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
            // Out-of-range symbols do not advance the rolling key.
            if (r_roll && !w_in_err) r_key <= mod26_add(r_key, r_step);
          end
        end
        default: r_state <= ST_NOKEY;
      endcase
    end
  end

endmodule
